// File: rtl/code_checker_if.sv
// Request/response bundle between the code-entry front end and the code checker.
// The front end drives the master side; the checker is the slave.
interface code_checker_if #(
  parameter int CODE_W = 7
);
  logic              chk_req;
  logic [CODE_W-1:0] chk_code;
  logic              set_req;
  logic              set_en;
  logic [CODE_W-1:0] set_code;
  logic              clear;
  logic              grant;
  logic              deny;
  logic              set_ack;
  logic              busy;
  logic              alarm;
  logic [1:0]        fail_count;

  modport master (
    output chk_req, chk_code, set_req, set_en, set_code, clear,
    input  grant, deny, set_ack, busy, alarm, fail_count
  );

  modport slave (
    input  chk_req, chk_code, set_req, set_en, set_code, clear,
    output grant, deny, set_ack, busy, alarm, fail_count
  );
endinterface

// File: rtl/code_checker.sv
// Password verifier for the lock: compares a candidate against the stored code,
// tracks consecutive failures, enforces a timed lockout and latches an alarm.
module code_checker #(
  parameter int CODE_W         = 7,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 1000
) (
  input logic           clk,
  input logic           rst,
  code_checker_if.slave bus
);

  typedef enum logic [1:0] {IDLE, COMPARE, LOCKOUT, ALARM} state_t;

  localparam logic [1:0]  MAX_F   = 2'(MAX_FAILS);
  localparam logic [15:0] LOCK_LD = 16'(LOCKOUT_CYCLES);

  state_t            state, next_state;
  logic [CODE_W-1:0] stored, stored_n;
  logic [CODE_W-1:0] cand, cand_n;
  logic [1:0]        fails, fails_n, fails_inc;
  logic [15:0]       cnt, cnt_n;
  logic              phase, phase_n;
  logic              grant_n, deny_n, ack_n;

  assign fails_inc = (fails == MAX_F) ? fails : fails + 2'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      stored         <= '0;
      cand           <= '0;
      fails          <= '0;
      cnt            <= '0;
      phase          <= 1'b0;
      bus.grant      <= 1'b0;
      bus.deny       <= 1'b0;
      bus.set_ack    <= 1'b0;
      bus.busy       <= 1'b0;
      bus.alarm      <= 1'b0;
      bus.fail_count <= '0;
    end else begin
      state          <= next_state;
      stored         <= stored_n;
      cand           <= cand_n;
      fails          <= fails_n;
      cnt            <= cnt_n;
      phase          <= phase_n;
      bus.grant      <= grant_n;
      bus.deny       <= deny_n;
      bus.set_ack    <= ack_n;
      bus.busy       <= (state != IDLE) && (next_state != IDLE);
      bus.alarm      <= (next_state == ALARM);
      bus.fail_count <= fails_n;
    end
  end

  // COMPARE spans two cycles (phase 0 then 1) so the verdict lands two edges after
  // the request while busy only rises one edge after it. clear beats every request.
  always_comb begin
    next_state = state;
    stored_n   = stored;
    cand_n     = cand;
    fails_n    = fails;
    cnt_n      = cnt;
    phase_n    = phase;
    grant_n    = 1'b0;
    deny_n     = 1'b0;
    ack_n      = 1'b0;

    case (state)
      IDLE: begin
        if (bus.clear) begin
          fails_n = '0;
        end else if (bus.chk_req) begin
          cand_n     = bus.chk_code;
          phase_n    = 1'b0;
          next_state = COMPARE;
        end else if (bus.set_req && bus.set_en) begin
          stored_n = bus.set_code;
          ack_n    = 1'b1;
        end
      end

      COMPARE: begin
        if (bus.clear) begin
          fails_n    = '0;
          phase_n    = 1'b0;
          next_state = IDLE;
        end else if (!phase) begin
          phase_n = 1'b1;
        end else begin
          phase_n = 1'b0;
          if (cand == stored) begin
            grant_n    = 1'b1;
            fails_n    = '0;
            next_state = IDLE;
          end else begin
            deny_n  = 1'b1;
            fails_n = fails_inc;
            if (fails_inc == MAX_F) begin
              next_state = ALARM;
            end else begin
              cnt_n      = LOCK_LD;
              next_state = LOCKOUT;
            end
          end
        end
      end

      LOCKOUT: begin
        if (bus.clear) begin
          fails_n    = '0;
          cnt_n      = '0;
          next_state = IDLE;
        end else if (cnt <= 16'd1) begin
          cnt_n      = '0;
          next_state = IDLE;
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end

      ALARM: begin
        if (bus.clear) begin
          fails_n    = '0;
          cnt_n      = '0;
          next_state = IDLE;
        end
      end

      default: next_state = IDLE;
    endcase
  end

endmodule
